seq_detector_param: RTL and testbench

Parametrised serial pattern detector, next generation of the team's fixed 4-state loop FSM. Bits are accepted on a qualified serial input and compared against a compile-time PATTERN of PAT_W bits. A one-cycle match pulse is issued for each detection, with overlapping or non-overlapping detection selected by parameter. The current progress state is exported for debug and bench checking, and an optional saturating match counter is provided.

---
 rtl/seq_det_pkg.sv | 67 ++++++
 rtl/seq_det_table.sv | 29 ++
 rtl/seq_detector_param.sv | 97 +++++++++
 tb/tb_seq_detector_param.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: elaboration-time helpers for the parametrised serial pattern detector.
// Patterns are stored right-aligned in a 16-bit container. Bit PAT_W-1 is the first bit received.
package seq_det_pkg;

  localparam int unsigned MAX_PAT_W = 16;
  localparam int unsigned MIN_PAT_W = 2;

  typedef logic [MAX_PAT_W-1:0] pattern_t;

  // Width needed to hold a matched-prefix length in the range 0..width.
  function automatic int unsigned state_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Returns the pos-th received bit of the pattern, where pos 0 is the first bit on the wire.
  function automatic logic pat_bit(input pattern_t pattern, input int unsigned width,
                                   input int unsigned pos);
    return pattern[4'(width - 1 - pos)];
  endfunction

  // Longest proper prefix of the first len pattern bits that is also a suffix of them.
  function automatic int unsigned fail_len(input pattern_t pattern, input int unsigned width,
                                           input int unsigned len);
    int unsigned best;
    logic        ok;
    best = 0;
    for (int unsigned k = 1; k < MAX_PAT_W; k++) begin
      if (k < len) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < MAX_PAT_W; i++) begin
          if (i < k) begin
            if (pat_bit(pattern, width, i) != pat_bit(pattern, width, len - k + i)) ok = 1'b0;
          end
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  // Prefix length reached from state s on bit b. The result is width on a full match.
  function automatic int unsigned next_state(input pattern_t pattern, input int unsigned width,
                                             input int unsigned s, input logic b);
    int unsigned k;
    int unsigned res;
    logic        done;
    k    = s;
    res  = 0;
    done = 1'b0;
    // Each fail link strictly shortens k, so this loop always ends within MAX_PAT_W+1 passes.
    for (int unsigned it = 0; it <= MAX_PAT_W; it++) begin
      if (!done) begin
        if ((k < width) && (pat_bit(pattern, width, k) == b)) begin
          res  = k + 1;
          done = 1'b1;
        end else if (k == 0) begin
          res  = 0;
          done = 1'b1;
        end else begin
          k = fail_len(pattern, width, k);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_table.sv
// seq_det_table: constant next-state lookup indexed by {state, bit}, built at elaboration.
// Entries for unreachable states (state >= PAT_W) are zero.
module seq_det_table
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W   = 4,
  parameter pattern_t    PATTERN = pattern_t'(4'b1010),
  parameter int unsigned STATE_W = 3
) (
  input  logic [STATE_W-1:0] i_state,
  input  logic               i_bit,
  output logic [STATE_W-1:0] o_next_c
);

  localparam int unsigned TBL_N = 2 ** (STATE_W + 1);

  logic [STATE_W-1:0] w_tbl [TBL_N];

  // One constant entry per {state, bit} combination.
  for (genvar g = 0; g < TBL_N; g++) begin : g_row
    localparam int unsigned S = g / 2;
    localparam bit          B = ((g % 2) == 1);
    localparam int unsigned K = (S < PAT_W) ? next_state(PATTERN, PAT_W, S, B) : 0;
    assign w_tbl[g] = STATE_W'(K);
  end

  assign o_next_c = w_tbl[{i_state, i_bit}];

endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial detector for PATTERN (PAT_W bits, first bit received is the MSB).
// It issues a registered one-cycle match pulse, and supports overlapping or restart-after-match detection.
// Optional build macro MATCH_CNT_EN adds a saturating match counter. Without it, match_count is tied to 0.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned  PAT_W   = 4,
  parameter pattern_t     PATTERN = pattern_t'(4'b1010),
  parameter bit           OVERLAP = 1'b1,
  parameter int unsigned  CNT_W   = 8,
  localparam int unsigned STATE_W = state_w(PAT_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  output logic               out,
  output logic [STATE_W-1:0] cur_state,
  output logic [CNT_W-1:0]   match_count
);

  // Reject illegal configurations during elaboration.
  if ((PAT_W < MIN_PAT_W) || (PAT_W > MAX_PAT_W) || ((PATTERN >> PAT_W) != '0)) begin : g_bad_cfg
    $error("seq_detector_param: illegal PAT_W=%0d / PATTERN=%0h", PAT_W, PATTERN);
  end

  localparam logic [STATE_W-1:0] MATCH_LEN = STATE_W'(PAT_W);
  localparam logic [STATE_W-1:0] RESTART   =
    OVERLAP ? STATE_W'(fail_len(PATTERN, PAT_W, PAT_W)) : '0;

  logic [STATE_W-1:0] r_state;
  logic               r_out;
  logic [STATE_W-1:0] w_ext;
  logic [STATE_W-1:0] w_state_nxt;
  logic               w_out_nxt;
  logic               w_hit;

  seq_det_table #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .STATE_W (STATE_W)
  ) u_table (
    .i_state  (r_state),
    .i_bit    (in),
    .o_next_c (w_ext)
  );

  assign w_hit = in_valid && (w_ext == MATCH_LEN);

  // State and pulse registers. Reset wins over a valid bit on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Next state: hold on gaps. On a full match, fall back to the border or restart at 0.
  always_comb begin
    w_state_nxt = r_state;
    if (in_valid) begin
      w_state_nxt = w_hit ? RESTART : w_ext;
    end
  end

  // Pulse request: high only for a valid bit that completes the pattern.
  always_comb begin
    w_out_nxt = 1'b0;
    if (w_hit) begin
      w_out_nxt = 1'b1;
    end
  end

  assign out       = r_out;
  assign cur_state = r_state;

`ifdef MATCH_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating count of issued match pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_out_nxt && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign match_count = r_cnt;
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param. It runs two instances on a shared stimulus stream.
// Instance A uses OVERLAP=1 and CNT_W=2. Instance B uses OVERLAP=0 and CNT_W=8.
// Expected states and pulses are hand-derived for PATTERN 1010.
module tb_seq_detector_param;
  import seq_det_pkg::*;

  localparam int unsigned SW = state_w(4);
`ifdef MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [SW-1:0] sa;
    logic          oa;
    logic [1:0]    ca;
    logic [SW-1:0] sb;
    logic          ob;
    logic [7:0]    cb;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_bit = 1'b0;
  logic          out_a, out_b;
  logic [SW-1:0] state_a, state_b;
  logic [1:0]    cnt_a;
  logic [7:0]    cnt_b;

  int vectors = 0;
  int errors  = 0;
  int unsigned ca_m = 0;
  int unsigned cb_m = 0;

  seq_detector_param #(
    .PAT_W(4), .PATTERN(16'b1010), .OVERLAP(1'b1), .CNT_W(2)
  ) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .out(out_a), .cur_state(state_a), .match_count(cnt_a)
  );

  seq_detector_param #(
    .PAT_W(4), .PATTERN(16'b1010), .OVERLAP(1'b0), .CNT_W(8)
  ) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit),
    .out(out_b), .cur_state(state_b), .match_count(cnt_b)
  );

  always #5 clk = ~clk;

  // Drive one edge's inputs and queue the expected post-edge outputs of both instances.
  task automatic step(input bit r, input bit v, input bit b,
                      input int sa, input int oa, input int sb, input int ob);
    exp_t e;
    rst = r; in_valid = v; in_bit = b;
    if (r) begin
      ca_m = 0; cb_m = 0;
    end else begin
      if ((oa != 0) && (ca_m < 3))   ca_m++;
      if ((ob != 0) && (cb_m < 255)) cb_m++;
    end
    e.sa = SW'(sa);
    e.oa = 1'(oa);
    e.ca = CNT_ON ? 2'(ca_m) : 2'd0;
    e.sb = SW'(sb);
    e.ob = 1'(ob);
    e.cb = CNT_ON ? 8'(cb_m) : 8'd0;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expectation per active edge, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e = q.pop_front();
      vectors++;
      if ({state_a, out_a, cnt_a, state_b, out_b, cnt_b} !== m_e) begin
        errors++;
        $display("FAIL vec%0d: A st/out/cnt got %0d/%0b/%0d want %0d/%0b/%0d ; B got %0d/%0b/%0d want %0d/%0b/%0d",
                 vectors, state_a, out_a, cnt_a, m_e.sa, m_e.oa, m_e.ca,
                 state_b, out_b, cnt_b, m_e.sb, m_e.ob, m_e.cb);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    // Stream 1,0,1,0,1,0: overlap vs restart
    step(0, 1, 1, 1, 0, 1, 0);
    step(0, 1, 0, 2, 0, 2, 0);
    step(0, 1, 1, 3, 0, 3, 0);
    step(0, 1, 0, 2, 1, 0, 1);
    step(0, 1, 1, 3, 0, 1, 0);
    step(0, 1, 0, 2, 1, 2, 0);
    // Reset after activity clears state and counters
    step(1, 1, 1, 0, 0, 0, 0);
    // Mismatch recovery: 1,1,0,1,0
    step(0, 1, 1, 1, 0, 1, 0);
    step(0, 1, 1, 1, 0, 1, 0);
    step(0, 1, 0, 2, 0, 2, 0);
    step(0, 1, 1, 3, 0, 3, 0);
    step(0, 1, 0, 2, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    // 1,0,0 falls back to 0
    step(0, 1, 1, 1, 0, 1, 0);
    step(0, 1, 0, 2, 0, 2, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    // 1,0,1 then gaps with toggling input, then the completing bit
    step(0, 1, 1, 1, 0, 1, 0);
    step(0, 1, 0, 2, 0, 2, 0);
    step(0, 1, 1, 3, 0, 3, 0);
    step(0, 0, 0, 3, 0, 3, 0);
    step(0, 0, 1, 3, 0, 3, 0);
    step(0, 0, 0, 3, 0, 3, 0);
    step(0, 1, 0, 2, 1, 0, 1);
    // Back up to state 3, then reset wins over a completing bit
    step(0, 1, 1, 3, 0, 1, 0);
    step(0, 1, 0, 2, 1, 2, 0);
    step(0, 1, 1, 3, 0, 3, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    // Six 1,0 pairs: A matches 5 times and its 2-bit counter saturates. B matches 3 times.
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, (i == 0) ? 1 : 3, 0, (i % 2 == 0) ? 1 : 3, 0);
      step(0, 1, 0, 2, (i == 0) ? 0 : 1, (i % 2 == 0) ? 2 : 0, (i % 2 == 0) ? 0 : 1);
    end
    // A gap right after a pulse drops out and holds state
    step(0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 0, 2, 0, 0, 0);

    for (int i = 0; (i < 5) && (q.size() != 0); i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
